branch_predictor_unit: RTL and testbench



---
 rtl/branch_predictor_unit_pkg.sv | 37 +++
 rtl/branch_predictor_unit_if.sv | 52 +++++
 rtl/branch_predictor_unit_btb_table.sv | 53 +++++
 rtl/branch_predictor_unit.sv | 187 ++++++++++++++++++
 tb/tb_branch_predictor_unit.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_unit_pkg.sv
`default_nettype none
// ============================================================================
// branch_predictor_unit_pkg : shared types, constants and helpers for the BPU
// Rev 1.0
// ============================================================================
package branch_predictor_unit_pkg;

  // Widest PC the BTB entry type can carry; narrower builds zero-extend.
  localparam int BPU_MAX_XLEN = 64;

  localparam logic [1:0] PHT_INIT = 2'b01;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } bpu_state_t;

  typedef struct packed {
    logic                    valid;
    logic                    is_jump;
    logic [BPU_MAX_XLEN-1:0] tag;
    logic [BPU_MAX_XLEN-1:0] target;
  } btb_entry_t;

  function automatic logic [1:0] sat2_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != 2'b11)) begin
      nxt = ctr + 2'b01;
    end else if (!taken && (ctr != 2'b00)) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_unit_if.sv
`default_nettype none
// ============================================================================
// branch_predictor_unit_if : fetch lookup + execute update bus of the BPU
// Optional statistics signals: BPU_STATS_EN.  Rev 1.0
// ============================================================================
interface branch_predictor_unit_if #(
  parameter int XLEN         = 32,
  parameter int PHT_IDX_BITS = 8
);
  logic                    ready;
  logic                    lookup_valid;
  logic [XLEN-1:0]         lookup_pc;
  logic                    predict_taken;
  logic [XLEN-1:0]         predict_target;
  logic [PHT_IDX_BITS-1:0] predict_index;
  logic                    update_valid;
  logic [XLEN-1:0]         update_pc;
  logic [PHT_IDX_BITS-1:0] update_index;
  logic                    update_is_branch;
  logic                    update_taken;
  logic [XLEN-1:0]         update_target;
`ifdef BPU_STATS_EN
  logic                    update_mispredict;
  logic [31:0]             stat_branches;
  logic [31:0]             stat_mispredicts;
  logic [31:0]             stat_btb_misses;
`endif

  modport master (
    input  ready, predict_taken, predict_target, predict_index,
    output lookup_valid, lookup_pc,
    output update_valid, update_pc, update_index, update_is_branch,
    output update_taken, update_target
`ifdef BPU_STATS_EN
    , output update_mispredict
    , input  stat_branches, stat_mispredicts, stat_btb_misses
`endif
  );

  modport slave (
    output ready, predict_taken, predict_target, predict_index,
    input  lookup_valid, lookup_pc,
    input  update_valid, update_pc, update_index, update_is_branch,
    input  update_taken, update_target
`ifdef BPU_STATS_EN
    , input  update_mispredict
    , output stat_branches, stat_mispredicts, stat_btb_misses
`endif
  );

endinterface
`default_nettype wire

// File: rtl/branch_predictor_unit_btb_table.sv
`default_nettype none
// ============================================================================
// branch_predictor_unit_btb_table : direct-mapped BTB storage with tag compare
// and a per-entry clear port for the init sweep.  Rev 1.0
// ============================================================================
module branch_predictor_unit_btb_table
  import branch_predictor_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int TAG_W    = 25
) (
  input  logic                clk,
  input  logic                clear_en,
  input  logic [IDX_BITS-1:0] clear_idx,
  input  logic [IDX_BITS-1:0] rd_idx,
  input  logic [TAG_W-1:0]    rd_tag,
  output logic                rd_hit,
  output logic                rd_is_jump,
  output logic [XLEN-1:0]     rd_target,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  btb_entry_t          wr_entry
);
  localparam int DEPTH = 2 ** IDX_BITS;

  logic [DEPTH-1:0] valid_mem;
  logic [DEPTH-1:0] is_jump_mem;
  logic [TAG_W-1:0] tag_mem    [DEPTH];
  logic [XLEN-1:0]  target_mem [DEPTH];

  // Only valid bits are cleared; payload is don't-care until the entry is written.
  always_ff @(posedge clk) begin
    if (clear_en) begin
      valid_mem[clear_idx] <= 1'b0;
    end else if (wr_en) begin
      valid_mem[wr_idx]   <= wr_entry.valid;
      is_jump_mem[wr_idx] <= wr_entry.is_jump;
      tag_mem[wr_idx]     <= wr_entry.tag[TAG_W-1:0];
      target_mem[wr_idx]  <= wr_entry.target[XLEN-1:0];
    end
  end

  assign rd_hit     = valid_mem[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_is_jump = is_jump_mem[rd_idx];
  assign rd_target  = target_mem[rd_idx];

  // Entry type is sized for the widest PC; upper bits are zero in this build.
  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_entry.tag, wr_entry.target};

endmodule
`default_nettype wire

// File: rtl/branch_predictor_unit.sv
`default_nettype none
// ============================================================================
// branch_predictor_unit : gshare PHT + direct-mapped BTB, cleared by a
// sequential sweep after reset.  Optional statistics: BPU_STATS_EN.  Rev 1.0
// ============================================================================
module branch_predictor_unit
  import branch_predictor_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int PHT_IDX_BITS = 8,
  parameter int GHR_BITS     = 8,
  parameter int BTB_IDX_BITS = 6,
  parameter int PC_LSB       = 1
) (
  input logic                    clk,
  input logic                    reset,
  branch_predictor_unit_if.slave bus
);
  localparam int PHT_DEPTH  = 2 ** PHT_IDX_BITS;
  localparam int SWEEP_BITS = (PHT_IDX_BITS > BTB_IDX_BITS) ? PHT_IDX_BITS : BTB_IDX_BITS;
  localparam int TAG_W      = XLEN - PC_LSB - BTB_IDX_BITS;

  bpu_state_t              state;
  bpu_state_t              next_state;
  logic                    ready;
  logic [SWEEP_BITS-1:0]   sweep_cnt;
  logic                    sweep_last;
  logic [GHR_BITS-1:0]     ghr;
  logic [1:0]              pht [PHT_DEPTH];

  logic [PHT_IDX_BITS-1:0] lookup_pidx;
  logic [BTB_IDX_BITS-1:0] lookup_bidx;
  logic [TAG_W-1:0]        lookup_tag;
  logic [BTB_IDX_BITS-1:0] upd_bidx;
  logic [TAG_W-1:0]        upd_tag;
  logic                    upd_en;
  logic                    upd_branch;

  logic                    btb_clear;
  logic [BTB_IDX_BITS-1:0] btb_clear_idx;
  logic                    btb_hit;
  logic                    btb_is_jump;
  logic [XLEN-1:0]         btb_target;
  logic                    btb_wr_en;
  btb_entry_t              btb_wr_entry;
  logic                    taken;

  assign sweep_last = (sweep_cnt == {SWEEP_BITS{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    case (state)
      INIT: begin
        if (sweep_last) begin
          next_state = RUN;
        end
      end
      RUN: begin
        ready = 1'b1;
      end
      default: begin
        next_state = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || (state != INIT)) begin
      sweep_cnt <= '0;
    end else begin
      sweep_cnt <= sweep_cnt + SWEEP_BITS'(1);
    end
  end

  // The sweep covers the larger table; the smaller one is cleared on the low indices.
  generate
    if (SWEEP_BITS > BTB_IDX_BITS) begin : g_clear_partial
      assign btb_clear = (state == INIT) && (sweep_cnt[SWEEP_BITS-1:BTB_IDX_BITS] == '0);
    end else begin : g_clear_full
      assign btb_clear = (state == INIT);
    end
  endgenerate
  assign btb_clear_idx = sweep_cnt[BTB_IDX_BITS-1:0];

  assign lookup_pidx = bus.lookup_pc[PC_LSB +: PHT_IDX_BITS] ^ PHT_IDX_BITS'(ghr);
  assign lookup_bidx = bus.lookup_pc[PC_LSB +: BTB_IDX_BITS];
  assign lookup_tag  = bus.lookup_pc[XLEN-1 -: TAG_W];
  assign upd_bidx    = bus.update_pc[PC_LSB +: BTB_IDX_BITS];
  assign upd_tag     = bus.update_pc[XLEN-1 -: TAG_W];

  assign upd_en     = ready && bus.update_valid && !reset;
  assign upd_branch = upd_en && bus.update_is_branch;

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      pht[sweep_cnt[PHT_IDX_BITS-1:0]] <= PHT_INIT;
    end else if (upd_branch) begin
      pht[bus.update_index] <= sat2_update(pht[bus.update_index], bus.update_taken);
    end
  end

  // History is non-speculative: shifted only when a branch resolves.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd_branch) begin
      ghr <= (ghr << 1) | GHR_BITS'(bus.update_taken);
    end
  end

  assign btb_wr_en = upd_en && bus.update_taken;

  always_comb begin
    btb_wr_entry         = '0;
    btb_wr_entry.valid   = 1'b1;
    btb_wr_entry.is_jump = !bus.update_is_branch;
    btb_wr_entry.tag     = BPU_MAX_XLEN'(upd_tag);
    btb_wr_entry.target  = BPU_MAX_XLEN'(bus.update_target);
  end

  branch_predictor_unit_btb_table #(
    .XLEN     (XLEN),
    .IDX_BITS (BTB_IDX_BITS),
    .TAG_W    (TAG_W)
  ) u_btb (
    .clk        (clk),
    .clear_en   (btb_clear),
    .clear_idx  (btb_clear_idx),
    .rd_idx     (lookup_bidx),
    .rd_tag     (lookup_tag),
    .rd_hit     (btb_hit),
    .rd_is_jump (btb_is_jump),
    .rd_target  (btb_target),
    .wr_en      (btb_wr_en),
    .wr_idx     (upd_bidx),
    .wr_entry   (btb_wr_entry)
  );

  assign taken = ready && bus.lookup_valid && btb_hit && (btb_is_jump || pht[lookup_pidx][1]);

  assign bus.ready          = ready;
  assign bus.predict_taken  = taken;
  assign bus.predict_target = taken ? btb_target : '0;
  assign bus.predict_index  = ready ? lookup_pidx : '0;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc, bus.update_pc};

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
  logic [31:0] stat_btb_misses;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      stat_btb_misses  <= '0;
    end else begin
      if (upd_branch && (stat_branches != 32'hFFFF_FFFF)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (upd_en && bus.update_mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
      if (ready && bus.lookup_valid && !btb_hit && (stat_btb_misses != 32'hFFFF_FFFF)) begin
        stat_btb_misses <= stat_btb_misses + 32'd1;
      end
    end
  end

  assign bus.stat_branches    = stat_branches;
  assign bus.stat_mispredicts = stat_mispredicts;
  assign bus.stat_btb_misses  = stat_btb_misses;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_unit.sv
`default_nettype none
// ============================================================================
// tb_branch_predictor_unit : directed self-checking bench for branch_predictor_unit
// Rev 1.0
// ============================================================================
module tb_branch_predictor_unit;
  localparam int XLEN         = 32;
  localparam int PHT_IDX_BITS = 8;
  localparam int GHR_BITS     = 8;
  localparam int BTB_IDX_BITS = 6;
  localparam int PC_LSB       = 1;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  branch_predictor_unit_if #(.XLEN(XLEN), .PHT_IDX_BITS(PHT_IDX_BITS)) bus ();

  branch_predictor_unit #(
    .XLEN         (XLEN),
    .PHT_IDX_BITS (PHT_IDX_BITS),
    .GHR_BITS     (GHR_BITS),
    .BTB_IDX_BITS (BTB_IDX_BITS),
    .PC_LSB       (PC_LSB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic set_lookup(input logic v, input logic [31:0] pc);
    bus.lookup_valid = v;
    bus.lookup_pc    = pc;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [7:0] idx, input logic br,
                     input logic tk, input logic [31:0] tgt);
    bus.update_valid     = 1'b1;
    bus.update_pc        = pc;
    bus.update_index     = idx;
    bus.update_is_branch = br;
    bus.update_taken     = tk;
    bus.update_target    = tgt;
    @(posedge clk);
    #1;
    bus.update_valid = 1'b0;
  endtask

  // Not-taken branches at an unused index shift zeros into the history.
  task automatic shift_zeros(input int n);
    for (int i = 0; i < n; i++) upd(32'h0, 8'hFF, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    set_lookup(1'b1, 32'h100);
    checks++;
    if (bus.ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", bus.ready); end
    checks++;
    if (bus.predict_index !== 8'h00) begin failures++; $display("FAIL init_index got=%h exp=00", bus.predict_index); end
    // A jump update offered during the sweep must be dropped.
    bus.update_valid     = 1'b1;
    bus.update_pc        = 32'h100;
    bus.update_index     = 8'h00;
    bus.update_is_branch = 1'b0;
    bus.update_taken     = 1'b1;
    bus.update_target    = 32'h200;
    n = 0;
    while (bus.ready !== 1'b1 && n < 400) begin
      checks++;
      if (bus.predict_taken !== 1'b0 || bus.predict_target !== 32'h0) begin
        failures++;
        $display("FAIL init_predict cycle=%0d taken=%0b target=%h exp=0/0", n, bus.predict_taken, bus.predict_target);
      end
      @(posedge clk);
      #1;
      n++;
      bus.update_valid = 1'b0;
    end
    checks++;
    if (n != 256) begin failures++; $display("FAIL init_length got=%0d exp=256", n); end
    set_lookup(1'b1, 32'h100);
    checks++;
    if (bus.predict_taken !== 1'b0) begin failures++; $display("FAIL init_update_ignored taken=%0b exp=0", bus.predict_taken); end
    checks++;
    if (bus.predict_index !== 8'h80) begin failures++; $display("FAIL run_index got=%h exp=80", bus.predict_index); end
  endtask

  task automatic test_jump();
    upd(32'h100, 8'h00, 1'b0, 1'b1, 32'h200);
    set_lookup(1'b1, 32'h100);
    checks++;
    if (bus.predict_taken !== 1'b1) begin failures++; $display("FAIL jump_taken got=%0b exp=1", bus.predict_taken); end
    checks++;
    if (bus.predict_target !== 32'h200) begin failures++; $display("FAIL jump_target got=%h exp=00000200", bus.predict_target); end
    set_lookup(1'b0, 32'h100);
    checks++;
    if (bus.predict_taken !== 1'b0 || bus.predict_target !== 32'h0) begin
      failures++;
      $display("FAIL jump_no_valid taken=%0b target=%h exp=0/0", bus.predict_taken, bus.predict_target);
    end
    checks++;
    if (bus.predict_index !== 8'h80) begin failures++; $display("FAIL index_no_valid got=%h exp=80", bus.predict_index); end
  endtask

  task automatic test_branch_warmup();
    upd(32'h80, 8'h40, 1'b1, 1'b1, 32'h40);
    shift_zeros(8);
    set_lookup(1'b1, 32'h80);
    checks++;
    if (bus.predict_index !== 8'h40) begin failures++; $display("FAIL warm_index got=%h exp=40", bus.predict_index); end
    checks++;
    if (bus.predict_taken !== 1'b1 || bus.predict_target !== 32'h40) begin
      failures++;
      $display("FAIL warm_taken_10 taken=%0b target=%h exp=1/00000040", bus.predict_taken, bus.predict_target);
    end
    upd(32'h80, 8'h40, 1'b1, 1'b0, 32'h40);
    checks++;
    if (bus.predict_taken !== 1'b0 || bus.predict_target !== 32'h0) begin
      failures++;
      $display("FAIL warm_ctr_01 taken=%0b target=%h exp=0/0", bus.predict_taken, bus.predict_target);
    end
    upd(32'h80, 8'h40, 1'b1, 1'b0, 32'h40);
    checks++;
    if (bus.predict_taken !== 1'b0) begin failures++; $display("FAIL warm_ctr_00 taken=%0b exp=0", bus.predict_taken); end
    // Further not-taken must saturate at 00, so one taken only reaches 01.
    upd(32'h80, 8'h40, 1'b1, 1'b0, 32'h40);
    checks++;
    if (bus.predict_taken !== 1'b0) begin failures++; $display("FAIL warm_sat_low taken=%0b exp=0", bus.predict_taken); end
    shift_zeros(0);
    upd(32'h80, 8'h40, 1'b1, 1'b1, 32'h40);
    shift_zeros(8);
    set_lookup(1'b1, 32'h80);
    checks++;
    if (bus.predict_taken !== 1'b0) begin failures++; $display("FAIL warm_sat_recover taken=%0b exp=0", bus.predict_taken); end
  endtask

  task automatic test_ghr();
    upd(32'h10, 8'h10, 1'b1, 1'b1, 32'h300);
    upd(32'h10, 8'h10, 1'b1, 1'b0, 32'h300);
    upd(32'h10, 8'h10, 1'b1, 1'b1, 32'h300);
    upd(32'h10, 8'h10, 1'b1, 1'b1, 32'h300);
    set_lookup(1'b0, 32'h0);
    checks++;
    if (bus.predict_index !== 8'h0B) begin failures++; $display("FAIL ghr_index got=%h exp=0b", bus.predict_index); end
    set_lookup(1'b1, 32'h10);
    checks++;
    if (bus.predict_index !== 8'h03) begin failures++; $display("FAIL ghr_xor_index got=%h exp=03", bus.predict_index); end
    checks++;
    if (bus.predict_taken !== 1'b0 || bus.predict_target !== 32'h0) begin
      failures++;
      $display("FAIL ghr_weak_counter taken=%0b target=%h exp=0/0", bus.predict_taken, bus.predict_target);
    end
  endtask

  task automatic test_aliasing();
    upd(32'h100, 8'h00, 1'b0, 1'b1, 32'h111);
    upd(32'h180, 8'h00, 1'b0, 1'b1, 32'h222);
    set_lookup(1'b1, 32'h100);
    checks++;
    if (bus.predict_taken !== 1'b0 || bus.predict_target !== 32'h0) begin
      failures++;
      $display("FAIL alias_evicted taken=%0b target=%h exp=0/0", bus.predict_taken, bus.predict_target);
    end
    set_lookup(1'b1, 32'h180);
    checks++;
    if (bus.predict_taken !== 1'b1 || bus.predict_target !== 32'h222) begin
      failures++;
      $display("FAIL alias_resident taken=%0b target=%h exp=1/00000222", bus.predict_taken, bus.predict_target);
    end
    set_lookup(1'b0, 32'h0);
    checks++;
    if (bus.predict_index !== 8'h0B) begin failures++; $display("FAIL jump_keeps_ghr got=%h exp=0b", bus.predict_index); end
  endtask

  task automatic test_collision();
    bus.update_valid     = 1'b1;
    bus.update_pc        = 32'h20;
    bus.update_index     = 8'h00;
    bus.update_is_branch = 1'b0;
    bus.update_taken     = 1'b1;
    bus.update_target    = 32'h500;
    set_lookup(1'b1, 32'h20);
    checks++;
    if (bus.predict_taken !== 1'b0) begin failures++; $display("FAIL coll_alloc_before taken=%0b exp=0", bus.predict_taken); end
    @(posedge clk);
    #1;
    bus.update_valid = 1'b0;
    #1;
    checks++;
    if (bus.predict_taken !== 1'b1 || bus.predict_target !== 32'h500) begin
      failures++;
      $display("FAIL coll_alloc_after taken=%0b target=%h exp=1/00000500", bus.predict_taken, bus.predict_target);
    end
    bus.update_valid  = 1'b1;
    bus.update_pc     = 32'h180;
    bus.update_target = 32'h333;
    set_lookup(1'b1, 32'h180);
    checks++;
    if (bus.predict_target !== 32'h222) begin failures++; $display("FAIL coll_overwrite_before got=%h exp=00000222", bus.predict_target); end
    @(posedge clk);
    #1;
    bus.update_valid = 1'b0;
    #1;
    checks++;
    if (bus.predict_target !== 32'h333) begin failures++; $display("FAIL coll_overwrite_after got=%h exp=00000333", bus.predict_target); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] pcs [4];
    int n;
    pcs[0] = 32'h20;
    pcs[1] = 32'h180;
    pcs[2] = 32'h10;
    pcs[3] = 32'h80;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_lookup(1'b1, 32'h180);
    checks++;
    if (bus.ready !== 1'b0 || bus.predict_taken !== 1'b0) begin
      failures++;
      $display("FAIL midreset_drop ready=%0b taken=%0b exp=0/0", bus.ready, bus.predict_taken);
    end
    wait_ready(n);
    checks++;
    if (n != 256) begin failures++; $display("FAIL midreset_sweep_len got=%0d exp=256", n); end
    for (int i = 0; i < 4; i++) begin
      set_lookup(1'b1, pcs[i]);
      checks++;
      if (bus.predict_taken !== 1'b0 || bus.predict_target !== 32'h0) begin
        failures++;
        $display("FAIL midreset_cleared pc=%h taken=%0b target=%h exp=0/0", pcs[i], bus.predict_taken, bus.predict_target);
      end
    end
    set_lookup(1'b0, 32'h0);
    checks++;
    if (bus.predict_index !== 8'h00) begin failures++; $display("FAIL midreset_ghr got=%h exp=00", bus.predict_index); end
  endtask

  initial begin
    reset                = 1'b1;
    bus.lookup_valid     = 1'b0;
    bus.lookup_pc        = '0;
    bus.update_valid     = 1'b0;
    bus.update_pc        = '0;
    bus.update_index     = '0;
    bus.update_is_branch = 1'b0;
    bus.update_taken     = 1'b0;
    bus.update_target    = '0;
`ifdef BPU_STATS_EN
    bus.update_mispredict = 1'b0;
`endif
    test_reset();
    test_jump();
    test_branch_warmup();
    test_ghr();
    test_aliasing();
    test_collision();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
